// File: rtl/led_chase_pkg.sv
// Shared types and constants for the dual-colour LED chaser.
package led_chase_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2
    } chase_state_t;

    localparam int SPEED_W   = 2;
    localparam int MAX_SHIFT = 3;

endpackage

// File: rtl/led_step_tick.sv
// Step prescaler: emits a 1-cycle tick every (BASE_DIV << speed_sel) running cycles.
module led_step_tick
    import led_chase_pkg::*;
#(
    parameter int BASE_DIV = 2**20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed_sel,
    output logic               tick
);

    localparam int CW = $clog2(BASE_DIV << MAX_SHIFT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] limit;

    // A lower speed_sel while cnt is past the new limit lets cnt wrap through its maximum.
    assign limit = CW'((BASE_DIV << speed_sel) - 1);
    assign tick  = run && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_chase_ctrl.sv
// Run-control sequencer for the dual-colour LED chaser with registered bar outputs.
// Optional LED_CHASE_SWEEP_CNT_EN adds an 8-bit round-trip counter output.
module led_chase_ctrl
    import led_chase_pkg::*;
#(
    parameter int LEDS     = 8,
    parameter int WIN      = 3,
    parameter int BASE_DIV = 2**20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [SPEED_W-1:0] speed_sel,
    output logic [LEDS-1:0]    shift_red,
    output logic [LEDS-1:0]    shift_green,
    output logic               ctl_bit,
    output logic               busy,
`ifdef LED_CHASE_SWEEP_CNT_EN
    output logic               sweep_done,
    output logic [7:0]         sweep_cnt
`else
    output logic               sweep_done
`endif
);

    localparam int PW = (LEDS > 2) ? $clog2(LEDS) : 1;
    localparam logic [PW-1:0] POS_END = PW'(LEDS - WIN);

    chase_state_t    state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [LEDS-1:0] win_d;
    logic [LEDS-1:0] red_q, green_q;
    logic            busy_q;
    logic            done_q, done_d;
    logic            run, clear, tick;

    assign run   = (state_q != IDLE) && !pause;
    assign clear = stop || (state_q == IDLE);

    led_step_tick #(
        .BASE_DIV (BASE_DIV)
    ) u_step_tick (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .clear     (clear),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            pos_d   = POS_END;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !pause) begin
                        state_d = RED;
                        pos_d   = POS_END;
                    end
                end
                RED: begin
                    if (tick) begin
                        if (pos_q == '0) begin
                            state_d = GREEN;
                            pos_d   = PW'(1);
                        end else begin
                            pos_d = pos_q - PW'(1);
                        end
                    end
                end
                GREEN: begin
                    if (tick) begin
                        if (pos_q == POS_END) begin
                            state_d = RED;
                            pos_d   = POS_END - PW'(1);
                            done_d  = 1'b1;
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    pos_d   = POS_END;
                end
            endcase
        end
    end

    assign win_d = {{(LEDS - WIN){1'b0}}, {WIN{1'b1}}} << pos_d;

    // Bars are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= POS_END;
            red_q   <= '0;
            green_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            red_q   <= (state_d == RED)   ? win_d : '0;
            green_q <= (state_d == GREEN) ? win_d : '0;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign shift_red   = red_q;
    assign shift_green = green_q;
    assign ctl_bit     = busy_q;
    assign busy        = busy_q;
    assign sweep_done  = done_q;

`ifdef LED_CHASE_SWEEP_CNT_EN
    logic [7:0] sweep_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_cnt_q <= '0;
        end else if (stop) begin
            sweep_cnt_q <= '0;
        end else if (done_d) begin
            sweep_cnt_q <= sweep_cnt_q + 8'd1;
        end
    end

    assign sweep_cnt = sweep_cnt_q;
`else
`endif

endmodule
